// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller. CSR reads are combinational; the redirect is 1 cycle
// after trap entry or mret; the IRQ synchroniser adds 2 cycles. No backpressure: every event is taken at its edge.
module csr_trap_unit #(
  parameter int          XLEN      = 32,
  parameter int          NUM_LIRQ  = 4,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         csr_index,
  input  logic                csr_rd_en,
  input  logic                csr_wr_en,
  input  logic [1:0]          csr_op,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_ill,
  input  logic                retire,
  input  logic                exc_valid,
  input  logic [3:0]          exc_cause,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic [XLEN-1:0]     exc_pc,
  input  logic                int_take,
  input  logic                mret,
  input  logic                soft_int,
  input  logic                timer_int,
  input  logic                ext_int,
  input  logic [NUM_LIRQ-1:0] lirq,
  output logic                irq_pending,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc
);

  localparam logic [31:0] MIE_MASK = (((32'd1 << NUM_LIRQ) - 32'd1) << 16) | 32'h0000_0888;

  logic                mst_mie, mst_mpie;
  logic [31:0]         mie_r, mtvec, mscratch, mepc, mcause, mtval, mip;
  logic [CNT_W-1:0]    mcycle, minstret;
  logic [63:0]         mcycle_x, minstret_x;
  logic [NUM_LIRQ+2:0] sync1, sync2;
  logic                impl, wr_do, int_go, ret_go, trap;
  logic [31:0]         wval, pend, int_code, base, target;
  logic [4:0]          int_bit;

  assign mcycle_x   = 64'(mcycle);
  assign minstret_x = 64'(minstret);

  always_comb begin
    mip = '0;
    mip[3]  = sync2[0];
    mip[7]  = sync2[1];
    mip[11] = sync2[2];
    mip[16 +: NUM_LIRQ] = sync2[3 +: NUM_LIRQ];
  end

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    case (csr_index)
      12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      12'h304: csr_rdata = mie_r;
      12'h305: csr_rdata = mtvec;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'h343: csr_rdata = mtval;
      12'h344: csr_rdata = mip;
      12'hB00: csr_rdata = mcycle_x[31:0];
      12'hB80: csr_rdata = mcycle_x[63:32];
      12'hB02: csr_rdata = minstret_x[31:0];
      12'hB82: csr_rdata = minstret_x[63:32];
      default: impl = 1'b0;
    endcase
  end

  assign csr_ill = (csr_rd_en | csr_wr_en) & (~impl | (csr_wr_en & (csr_index == 12'h344)));

  always_comb begin
    case (csr_op)
      2'b00:   wval = csr_wdata;
      2'b01:   wval = csr_rdata | csr_wdata;
      2'b10:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Later assignments win, so the loop plus the trailing ifs give MEI > MSI > MTI > high lirq.
  always_comb begin
    pend    = mie_r & mip;
    int_bit = '0;
    for (int i = 0; i < NUM_LIRQ; i++)
      if (pend[16+i]) int_bit = 5'(16 + i);
    if (pend[7])  int_bit = 5'd7;
    if (pend[3])  int_bit = 5'd3;
    if (pend[11]) int_bit = 5'd11;
  end

  assign int_code    = {1'b1, 26'b0, int_bit};
  assign irq_pending = mst_mie & (|pend);
  assign int_go      = int_take & irq_pending & ~exc_valid;
  assign trap        = exc_valid | int_go;
  assign ret_go      = mret & ~trap;
  assign wr_do       = csr_wr_en & ~csr_ill & (csr_op != 2'b11) & ~trap & ~mret;
  assign base        = {mtvec[31:2], 2'b00};

  always_comb begin
    target = base;
    if (ret_go)
      target = mepc;
    else if (int_go && mtvec[1:0] == 2'b01)
      target = base + {25'b0, int_bit, 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie <= 1'b0;  mst_mpie <= 1'b0;
      mie_r <= '0;  mtvec <= MTVEC_RST;  mscratch <= '0;
      mepc <= '0;  mcause <= '0;  mtval <= '0;
      mcycle <= '0;  minstret <= '0;
      sync1 <= '0;  sync2 <= '0;
      redirect_valid <= 1'b0;  redirect_pc <= '0;
    end else begin
      sync1 <= {lirq, ext_int, timer_int, soft_int};
      sync2 <= sync1;
      redirect_valid <= trap | ret_go;
      if (trap | ret_go) redirect_pc <= target;

      if (trap) begin
        mepc     <= exc_pc & ~32'h3;
        mcause   <= exc_valid ? {28'b0, exc_cause} : int_code;
        mtval    <= exc_valid ? exc_tval : 32'h0;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (ret_go) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_do) begin
        case (csr_index)
          12'h300: begin mst_mie <= wval[3]; mst_mpie <= wval[7]; end
          12'h304: mie_r    <= wval & MIE_MASK;
          12'h305: mtvec    <= wval & ~32'h2;
          12'h340: mscratch <= wval;
          12'h341: mepc     <= wval & ~32'h3;
          12'h342: mcause   <= wval;
          12'h343: mtval    <= wval;
          default: ;
        endcase
      end

      // A write to either counter half replaces it and skips that counter's increment.
      if (wr_do && csr_index == 12'hB00)      mcycle[31:0]       <= wval;
      else if (wr_do && csr_index == 12'hB80) mcycle[CNT_W-1:32] <= wval[CNT_W-33:0];
      else                                    mcycle             <= mcycle + CNT_W'(1);

      if (wr_do && csr_index == 12'hB02)      minstret[31:0]       <= wval;
      else if (wr_do && csr_index == 12'hB82) minstret[CNT_W-1:32] <= wval[CNT_W-33:0];
      else if (retire)                        minstret             <= minstret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed vectors, a per-cycle reference model, and literal anchor checks.
module tb_csr_trap_unit;
  localparam int NL = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [11:0]   csr_index = '0;
  logic          csr_rd_en = 0, csr_wr_en = 0;
  logic [1:0]    csr_op = '0;
  logic [31:0]   csr_wdata = '0, csr_rdata;
  logic          csr_ill, retire = 0, exc_valid = 0, int_take = 0, mret = 0;
  logic [3:0]    exc_cause = '0;
  logic [31:0]   exc_tval = '0, exc_pc = '0, redirect_pc;
  logic          soft_int = 0, timer_int = 0, ext_int = 0, irq_pending, redirect_valid;
  logic [NL-1:0] lirq = '0;

  int checks = 0, errors = 0;

  csr_trap_unit #(.XLEN(32), .NUM_LIRQ(NL), .CNT_W(64), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .csr_index(csr_index), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_ill(csr_ill),
    .retire(retire), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .exc_pc(exc_pc), .int_take(int_take), .mret(mret), .soft_int(soft_int),
    .timer_int(timer_int), .ext_int(ext_int), .lirq(lirq), .irq_pending(irq_pending),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state held as plain values.
  bit              m_mie, m_mpie, m_rv;
  bit [31:0]       m_ie, m_tvec, m_scr, m_epc, m_cause, m_tval, m_rpc, m_s1, m_s2;
  longint unsigned m_cyc, m_ins;

  function automatic bit [31:0] raw_irq();
    return {12'b0, lirq, 4'b0, ext_int, 3'b0, timer_int, 3'b0, soft_int, 3'b0};
  endfunction

  function automatic void m_read(input bit [11:0] idx, output bit [31:0] v, output bit ok);
    ok = 1'b1;
    case (idx)
      12'h300: v = {19'b0, 2'b11, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scr;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344: v = m_s2;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      default: begin v = 32'h0; ok = 1'b0; end
    endcase
  endfunction

  function automatic bit m_ill();
    bit [31:0] v;
    bit ok;
    m_read(csr_index, v, ok);
    return (csr_rd_en || csr_wr_en) && (!ok || (csr_wr_en && csr_index == 12'h344));
  endfunction

  function automatic int m_pick(input bit [31:0] p);
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    for (int i = NL - 1; i >= 0; i--)
      if (p[16+i]) return 16 + i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit [31:0] pend, old, nv, base;
    bit ok, pflag, take, ret_go, wr_go, cinc, iinc;
    int b;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_rv = 0; m_ie = 0; m_tvec = 0; m_scr = 0; m_epc = 0;
      m_cause = 0; m_tval = 0; m_rpc = 0; m_s1 = 0; m_s2 = 0; m_cyc = 0; m_ins = 0;
    end else begin
      pend  = m_ie & m_s2;
      pflag = m_mie && pend != 0;
      b     = m_pick(pend);
      m_read(csr_index, old, ok);
      case (csr_op)
        2'b00: nv = csr_wdata;
        2'b01: nv = old | csr_wdata;
        2'b10: nv = old & ~csr_wdata;
        default: nv = old;
      endcase
      base   = m_tvec & ~32'h3;
      take   = int_take && pflag && !exc_valid;
      ret_go = mret && !exc_valid && !take;
      wr_go  = csr_wr_en && !m_ill() && csr_op != 2'b11 && !exc_valid && !take && !mret;
      cinc = 1; iinc = retire;
      if (exc_valid) begin
        m_epc = exc_pc & ~32'h3; m_cause = {28'b0, exc_cause}; m_tval = exc_tval;
        m_mpie = m_mie; m_mie = 0; m_rpc = base;
      end else if (take) begin
        m_epc = exc_pc & ~32'h3; m_cause = 32'h8000_0000 | 32'(b); m_tval = 0;
        m_mpie = m_mie; m_mie = 0;
        m_rpc = (m_tvec[1:0] == 2'b01) ? base + 32'(4 * b) : base;
      end else if (ret_go) begin
        m_rpc = m_epc; m_mie = m_mpie; m_mpie = 1;
      end else if (wr_go) begin
        case (csr_index)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_ie = nv & 32'h000F_0888;
          12'h305: m_tvec = nv & ~32'h2;
          12'h340: m_scr = nv;
          12'h341: m_epc = nv & ~32'h3;
          12'h342: m_cause = nv;
          12'h343: m_tval = nv;
          12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cinc = 0; end
          12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cinc = 0; end
          12'hB02: begin m_ins = {m_ins[63:32], nv}; iinc = 0; end
          12'hB82: begin m_ins = {nv, m_ins[31:0]}; iinc = 0; end
          default: ;
        endcase
      end
      m_rv = exc_valid || take || ret_go;
      if (cinc) m_cyc = m_cyc + 1;
      if (iinc) m_ins = m_ins + 1;
      m_s2 = m_s1;
      m_s1 = raw_irq();
    end
  end

  always @(negedge clk) begin
    bit [31:0] v;
    bit ok;
    if (!rst) begin
      m_read(csr_index, v, ok);
      chk("cmp_rdata", csr_rdata, v);
      chk("cmp_ill", {31'b0, csr_ill}, {31'b0, m_ill()});
      chk("cmp_irq_pending", {31'b0, irq_pending}, {31'b0, m_mie && (m_ie & m_s2) != 0});
      chk("cmp_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
      if (m_rv) chk("cmp_redirect_pc", redirect_pc, m_rpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] d);
    csr_index = idx; csr_op = op; csr_wdata = d; csr_wr_en = 1;
    tick();
    csr_wr_en = 0;
  endtask

  task automatic rd(input logic [11:0] idx, input logic [31:0] exp, input string nm);
    csr_index = idx; csr_rd_en = 1;
    #1;
    chk(nm, csr_rdata, exp);
    csr_rd_en = 0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    // Reset mid-count, with minstret also advanced.
    repeat (5) tick();
    retire = 1; tick(); tick(); retire = 0;
    tick();
    rst = 1;
    #1;
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    tick(); tick();
    rst = 0;
    rd(12'hB00, 32'h0, "rst_mcycle_lo");
    rd(12'hB80, 32'h0, "rst_mcycle_hi");
    rd(12'hB02, 32'h0, "rst_minstret_lo");
    rd(12'hB82, 32'h0, "rst_minstret_hi");
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    tick();
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h305, 32'h0, "rst_mtvec");
    rd(12'h340, 32'h0, "rst_mscratch");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h343, 32'h0, "rst_mtval");
    rd(12'h344, 32'h0, "rst_mip");

    // Vectored timer interrupt.
    wr(12'h305, 2'b00, 32'h1001);
    wr(12'h304, 2'b00, 32'h80);
    wr(12'h300, 2'b00, 32'h8);
    timer_int = 1;
    tick();
    chk("tmr_pending_1clk", {31'b0, irq_pending}, 32'h0);
    tick();
    chk("tmr_pending_2clk", {31'b0, irq_pending}, 32'h1);
    int_take = 1; exc_pc = 32'h200;
    tick();
    int_take = 0;
    chk("tmr_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("tmr_redirect_pc", redirect_pc, 32'h101C);
    rd(12'h342, 32'h8000_0007, "tmr_mcause");
    rd(12'h341, 32'h200, "tmr_mepc");
    rd(12'h300, 32'h0000_1880, "tmr_mstatus");
    tick();
    chk("tmr_redirect_pulse", {31'b0, redirect_valid}, 32'h0);
    timer_int = 0;

    // Exception beats a simultaneous interrupt take; then mret.
    wr(12'h304, 2'b00, 32'h800);
    ext_int = 1;
    wr(12'h300, 2'b00, 32'h8);
    tick();
    chk("prec_pending", {31'b0, irq_pending}, 32'h1);
    exc_valid = 1; exc_cause = 4'd2; exc_tval = 32'hDEAD; exc_pc = 32'h300; int_take = 1;
    tick();
    exc_valid = 0; int_take = 0;
    chk("prec_redirect_pc", redirect_pc, 32'h1000);
    rd(12'h342, 32'h2, "prec_mcause");
    rd(12'h343, 32'hDEAD, "prec_mtval");
    rd(12'h341, 32'h300, "prec_mepc");
    mret = 1;
    tick();
    mret = 0;
    chk("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    chk("mret_redirect_pc", redirect_pc, 32'h300);
    rd(12'h300, 32'h0000_1888, "mret_mstatus");
    ext_int = 0;
    wr(12'h304, 2'b00, 32'h0);

    // Counter write suppresses increment, then carries into hi.
    wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "cnt_lo_written");
    rd(12'hB80, 32'h0, "cnt_hi_before");
    tick();
    rd(12'hB00, 32'h0, "cnt_lo_wrap");
    rd(12'hB80, 32'h1, "cnt_hi_carry");
    retire = 1;
    repeat (3) tick();
    retire = 0;
    rd(12'hB02, 32'h3, "minstret_3");

    // Atomic ops, read-only mip, reserved op.
    wr(12'h304, 2'b00, 32'h888);
    rd(12'h304, 32'h888, "mie_write");
    wr(12'h304, 2'b10, 32'h8);
    rd(12'h304, 32'h880, "mie_clear");
    wr(12'h304, 2'b01, 32'h1_0000);
    rd(12'h304, 32'h1_0880, "mie_set");
    csr_index = 12'h344; csr_op = 2'b00; csr_wdata = 32'hFFFF_FFFF; csr_wr_en = 1;
    #1;
    chk("mip_write_ill", {31'b0, csr_ill}, 32'h1);
    tick();
    csr_wr_en = 0;
    rd(12'h344, 32'h0, "mip_unchanged");
    wr(12'h340, 2'b00, 32'h1234);
    wr(12'h340, 2'b11, 32'hFFFF);
    rd(12'h340, 32'h1234, "op11_no_write");

    // Local interrupt priority: lirq[2] over lirq[0].
    lirq = 4'b0101;
    wr(12'h304, 2'b00, 32'hF_0000);
    tick();
    chk("lirq_pending", {31'b0, irq_pending}, 32'h1);
    int_take = 1; exc_pc = 32'h400;
    tick();
    int_take = 0;
    chk("lirq_redirect_pc", redirect_pc, 32'h1048);
    rd(12'h342, 32'h8000_0012, "lirq_mcause");
    rd(12'h343, 32'h0, "lirq_mtval");
    lirq = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
